// File: rtl/lockstep_req_aligner.sv
// Lockstep request aligner: holds back a lockstep group's TCDM requests
// until every member core has issued one. It then compares the members
// against a reference core and forwards the group as one broadcast access.
// Divergence and arrival skew beyond TIMEOUT are reported as fault events.

// Per-core divergence check against the reference core's request fields.
module lockstep_lane_cmp #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int BE_WIDTH   = 4
) (
    input  logic                  in_grp,
    input  logic [ADDR_WIDTH-1:0] add,
    input  logic                  wen,
    input  logic [BE_WIDTH-1:0]   be,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [ADDR_WIDTH-1:0] ref_add,
    input  logic                  ref_wen,
    input  logic [BE_WIDTH-1:0]   ref_be,
    input  logic [DATA_WIDTH-1:0] ref_wdata,
    output logic                  diverge
);
    // Write data only matters when the reference is writing (wen active low).
    assign diverge = in_grp & ((add != ref_add) | (wen != ref_wen) | (be != ref_be) |
                               (~ref_wen & (wdata != ref_wdata)));
endmodule

module lockstep_req_aligner #(
    parameter int NB_CORES   = 8,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int BE_WIDTH   = 4,
    parameter int TIMEOUT    = 16,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic                           lockstep_mode_i,
    input  logic [NB_CORES-1:0]            core_mask_i,
    input  logic [NB_CORES-1:0]            req_i,
    input  logic [NB_CORES*ADDR_WIDTH-1:0] add_i,
    input  logic [NB_CORES-1:0]            wen_i,
    input  logic [NB_CORES*BE_WIDTH-1:0]   be_i,
    input  logic [NB_CORES*DATA_WIDTH-1:0] wdata_i,
    input  logic [NB_CORES-1:0]            gnt_i,
    output logic [NB_CORES-1:0]            req_o,
    output logic                           same_address_o,
    output logic                           mismatch_o,
    output logic [NB_CORES-1:0]            diverged_o,
    output logic                           timeout_o,
    input  logic                           err_clear_i,
    output logic                           err_sticky_o,
    output logic [CNT_WIDTH-1:0]           fault_cnt_o
);
    localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam int IW = (NB_CORES > 1) ? $clog2(NB_CORES) : 1;

    typedef enum logic [1:0] {IDLE, COLLECT, HOLD} state_e;

    state_e                state_q, state_d;
    logic [TW-1:0]         timer_q, timer_d;
    logic                  mis_q, mis_d;

    logic [NB_CORES-1:0][ADDR_WIDTH-1:0] add_v;
    logic [NB_CORES-1:0][BE_WIDTH-1:0]   be_v;
    logic [NB_CORES-1:0][DATA_WIDTH-1:0] wdata_v;

    logic [NB_CORES-1:0] grp, arrived, div, grp_req;
    logic                active, all_arr, any_arr, any_div;
    logic                mismatch, timeout;
    logic [IW-1:0]       ref_idx;

    assign add_v   = add_i;
    assign be_v    = be_i;
    assign wdata_v = wdata_i;

    assign grp     = core_mask_i;
    assign arrived = req_i & grp;
    assign all_arr = (arrived == grp);
    assign any_arr = |arrived;
    // A group needs at least two members; clearing the lowest bit tests that.
    assign active  = lockstep_mode_i & ((grp & (grp - NB_CORES'(1))) != '0);

    // Reference core is the lowest-indexed group member.
    always_comb begin
        ref_idx = '0;
        for (int k = NB_CORES - 1; k >= 0; k--)
            if (grp[k]) ref_idx = IW'(k);
    end

    for (genvar k = 0; k < NB_CORES; k++) begin : g_lane
        lockstep_lane_cmp #(
            .ADDR_WIDTH(ADDR_WIDTH),
            .DATA_WIDTH(DATA_WIDTH),
            .BE_WIDTH  (BE_WIDTH)
        ) u_cmp (
            .in_grp   (grp[k]),
            .add      (add_v[k]),
            .wen      (wen_i[k]),
            .be       (be_v[k]),
            .wdata    (wdata_v[k]),
            .ref_add  (add_v[ref_idx]),
            .ref_wen  (wen_i[ref_idx]),
            .ref_be   (be_v[ref_idx]),
            .ref_wdata(wdata_v[ref_idx]),
            .diverge  (div[k])
        );
    end

    assign any_div = |div;

    // FSM state, collect timer and registered compare result.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            timer_q <= '0;
            mis_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            mis_q   <= mis_d;
        end
    end

    // Next state, compare/timeout pulses and the group request release.
    always_comb begin
        state_d  = state_q;
        timer_d  = timer_q;
        mis_d    = mis_q;
        mismatch = 1'b0;
        timeout  = 1'b0;
        grp_req  = '0;
        if (!active) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (all_arr) begin
                        mismatch = any_div;
                        mis_d    = any_div;
                        state_d  = HOLD;
                    end else if (any_arr) begin
                        timer_d = '0;
                        state_d = COLLECT;
                    end
                end
                COLLECT: begin
                    timer_d = timer_q + TW'(1);
                    if (all_arr) begin
                        mismatch = any_div;
                        mis_d    = any_div;
                        state_d  = HOLD;
                    end else if (timer_q == TW'(TIMEOUT - 1)) begin
                        // Release what arrived as independent accesses.
                        timeout = 1'b1;
                        mis_d   = 1'b1;
                        state_d = HOLD;
                    end else if (!any_arr) begin
                        state_d = IDLE;
                    end
                end
                HOLD: begin
                    grp_req = arrived;
                    if ((arrived & ~gnt_i) == '0) state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Non-group cores always bypass; group cores only see requests in HOLD.
    always_comb begin
        if (!active) begin
            req_o          = req_i;
            same_address_o = 1'b0;
        end else begin
            req_o          = (req_i & ~grp) | grp_req;
            same_address_o = (state_q == HOLD) & ~mis_q;
        end
    end

    assign mismatch_o = mismatch & rst_ni;
    assign timeout_o  = timeout & rst_ni;
    assign diverged_o = mismatch_o ? div : '0;

    // Sticky error flag and saturating fault counter; clear beats an event.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            err_sticky_o <= 1'b0;
            fault_cnt_o  <= '0;
        end else if (err_clear_i) begin
            err_sticky_o <= 1'b0;
            fault_cnt_o  <= '0;
        end else if (mismatch_o | timeout_o) begin
            err_sticky_o <= 1'b1;
            if (fault_cnt_o != '1) fault_cnt_o <= fault_cnt_o + CNT_WIDTH'(1);
        end
    end
endmodule

// File: tb/tb_lockstep_req_aligner.sv
// Scoreboard bench for lockstep_req_aligner: each driven cycle pushes its
// expected outputs; a negedge monitor pops and compares them.
module tb_lockstep_req_aligner;
    localparam int N   = 8;
    localparam int CW  = 3;

    typedef struct {
        string          tag;
        logic [N-1:0]   req;
        logic           sa;
        logic           mis;
        logic [N-1:0]   div;
        logic           to;
        logic           sticky;
        logic [CW-1:0]  cnt;
    } exp_t;

    logic               clk = 1'b0;
    logic               rst_n, mode, clr;
    logic [N-1:0]       mask, req, wen, gnt;
    logic [N-1:0][31:0] add_v, wdata_v;
    logic [N-1:0][3:0]  be_v;
    logic [N-1:0]       req_o, div_o;
    logic               sa_o, mis_o, to_o, sticky_o;
    logic [CW-1:0]      cnt_o;

    exp_t               sb[$];
    int                 n_chk = 0, n_fail = 0;
    logic               exp_sticky = 1'b0;
    logic [CW-1:0]      exp_cnt = '0;

    always #5 clk = ~clk;

    lockstep_req_aligner #(
        .NB_CORES(N), .ADDR_WIDTH(32), .DATA_WIDTH(32), .BE_WIDTH(4),
        .TIMEOUT(16), .CNT_WIDTH(CW)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n), .lockstep_mode_i(mode), .core_mask_i(mask),
        .req_i(req), .add_i(add_v), .wen_i(wen), .be_i(be_v), .wdata_i(wdata_v),
        .gnt_i(gnt), .req_o(req_o), .same_address_o(sa_o), .mismatch_o(mis_o),
        .diverged_o(div_o), .timeout_o(to_o), .err_clear_i(clr),
        .err_sticky_o(sticky_o), .fault_cnt_o(cnt_o)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h want=%h", tag, act, exp);
        end
    endtask

    // Pop one expectation per cycle, sampled mid-cycle.
    always @(negedge clk) begin
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk({e.tag, ".req"},    32'(req_o),    32'(e.req));
            chk({e.tag, ".sa"},     32'(sa_o),     32'(e.sa));
            chk({e.tag, ".mis"},    32'(mis_o),    32'(e.mis));
            chk({e.tag, ".div"},    32'(div_o),    32'(e.div));
            chk({e.tag, ".to"},     32'(to_o),     32'(e.to));
            chk({e.tag, ".sticky"}, 32'(sticky_o), 32'(e.sticky));
            chk({e.tag, ".cnt"},    32'(cnt_o),    32'(e.cnt));
        end
    end

    task automatic set_all(input logic [31:0] a, input logic w, input logic [3:0] b,
                           input logic [31:0] d);
        for (int k = 0; k < N; k++) begin
            add_v[k] = a; wen[k] = w; be_v[k] = b; wdata_v[k] = d;
        end
    endtask

    // Drive one cycle, queue its expected outputs, then advance the
    // error-flag expectation from the expected pulses.
    task automatic cyc(input string tag, input logic [N-1:0] r, input logic [N-1:0] g,
                       input logic [N-1:0] ereq, input logic esa, input logic emis,
                       input logic [N-1:0] ediv, input logic eto);
        exp_t e;
        req = r; gnt = g;
        e.tag = tag; e.req = ereq; e.sa = esa; e.mis = emis; e.div = ediv; e.to = eto;
        e.sticky = exp_sticky; e.cnt = exp_cnt;
        sb.push_back(e);
        @(posedge clk); #1;
        if (!rst_n || clr) begin
            exp_sticky = 1'b0; exp_cnt = '0;
        end else if (emis || eto) begin
            exp_sticky = 1'b1;
            if (exp_cnt != '1) exp_cnt = exp_cnt + 1'b1;
        end
    endtask

    initial begin
        rst_n = 1'b0; mode = 1'b0; clr = 1'b0; mask = '0; req = '0; gnt = '0;
        set_all(32'h1000_0040, 1'b1, 4'hF, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        cyc("rst", 8'h00, 8'h00, 8'h00, 0, 0, 8'h00, 0);
        rst_n = 1'b1; mode = 1'b1; mask = 8'hFF;

        // Aligned group: forwarded one cycle after arrival, held until granted.
        cyc("al_c", 8'hFF, 8'h00, 8'h00, 0, 0, 8'h00, 0);
        cyc("al_h", 8'hFF, 8'h00, 8'hFF, 1, 0, 8'h00, 0);
        cyc("al_g", 8'hFF, 8'hFF, 8'hFF, 1, 0, 8'h00, 0);
        cyc("al_i", 8'h00, 8'h00, 8'h00, 0, 0, 8'h00, 0);

        // Skewed arrival: cores 0-3 first, 4-7 three cycles later.
        cyc("sk_0", 8'h0F, 8'h00, 8'h00, 0, 0, 8'h00, 0);
        cyc("sk_1", 8'h0F, 8'h00, 8'h00, 0, 0, 8'h00, 0);
        cyc("sk_2", 8'h0F, 8'h00, 8'h00, 0, 0, 8'h00, 0);
        cyc("sk_3", 8'hFF, 8'h00, 8'h00, 0, 0, 8'h00, 0);
        cyc("sk_h", 8'hFF, 8'hFF, 8'hFF, 1, 0, 8'h00, 0);
        cyc("sk_i", 8'h00, 8'h00, 8'h00, 0, 0, 8'h00, 0);

        // Write data divergence on core 5.
        set_all(32'h1000_0040, 1'b0, 4'hF, 32'hDEAD_BEEF);
        wdata_v[5] = 32'hDEAD_BEEE;
        cyc("wd_c", 8'hFF, 8'h00, 8'h00, 0, 1, 8'h20, 0);
        cyc("wd_h", 8'hFF, 8'hFF, 8'hFF, 0, 0, 8'h00, 0);
        cyc("wd_i", 8'h00, 8'h00, 8'h00, 0, 0, 8'h00, 0);

        // Same data difference is ignored on a read.
        wen = 8'hFF;
        cyc("rd_c", 8'hFF, 8'h00, 8'h00, 0, 0, 8'h00, 0);
        cyc("rd_h", 8'hFF, 8'hFF, 8'hFF, 1, 0, 8'h00, 0);

        // Address divergence on core 2.
        set_all(32'h1000_0040, 1'b1, 4'hF, 32'h0);
        add_v[2] = 32'h1000_0044;
        cyc("ad_c", 8'hFF, 8'h00, 8'h00, 0, 1, 8'h04, 0);
        cyc("ad_h", 8'hFF, 8'hFF, 8'hFF, 0, 0, 8'h00, 0);
        cyc("ad_i", 8'h00, 8'h00, 8'h00, 0, 0, 8'h00, 0);

        // Upper group: reference is core 4, lower cores bypass.
        set_all(32'h1000_0040, 1'b1, 4'hF, 32'h0);
        be_v[4] = 4'h3; mask = 8'hF0;
        cyc("be_c", 8'hFF, 8'h00, 8'h0F, 0, 1, 8'hE0, 0);
        cyc("be_h", 8'hFF, 8'hF0, 8'hFF, 0, 0, 8'h00, 0);
        cyc("be_i", 8'h00, 8'h00, 8'h00, 0, 0, 8'h00, 0);
        be_v[4] = 4'hF; mask = 8'hFF;

        // Core 7 never arrives: timeout on the 16th COLLECT cycle.
        cyc("to_s", 8'h7F, 8'h00, 8'h00, 0, 0, 8'h00, 0);
        for (int i = 0; i < 15; i++)
            cyc("to_w", 8'h7F, 8'h00, 8'h00, 0, 0, 8'h00, 0);
        cyc("to_p", 8'h7F, 8'h00, 8'h00, 0, 0, 8'h00, 1);
        cyc("to_h", 8'h7F, 8'h7F, 8'h7F, 0, 0, 8'h00, 0);
        clr = 1'b1;
        cyc("clr",  8'h00, 8'h00, 8'h00, 0, 0, 8'h00, 0);
        clr = 1'b0;
        cyc("clr_i", 8'h00, 8'h00, 8'h00, 0, 0, 8'h00, 0);

        // Withdrawn requests return to IDLE silently.
        cyc("wt_0", 8'h03, 8'h00, 8'h00, 0, 0, 8'h00, 0);
        cyc("wt_1", 8'h00, 8'h00, 8'h00, 0, 0, 8'h00, 0);
        cyc("wt_2", 8'h03, 8'h00, 8'h00, 0, 0, 8'h00, 0);
        cyc("wt_3", 8'hFF, 8'h00, 8'h00, 0, 0, 8'h00, 0);
        cyc("wt_h", 8'hFF, 8'hFF, 8'hFF, 1, 0, 8'h00, 0);
        cyc("wt_i", 8'h00, 8'h00, 8'h00, 0, 0, 8'h00, 0);

        // Counter saturation (3-bit counter).
        add_v[2] = 32'h1000_0044;
        for (int i = 0; i < 8; i++) begin
            cyc("sat_c", 8'hFF, 8'h00, 8'h00, 0, 1, 8'h04, 0);
            cyc("sat_h", 8'hFF, 8'hFF, 8'hFF, 0, 0, 8'h00, 0);
        end
        cyc("sat_i", 8'h00, 8'h00, 8'h00, 0, 0, 8'h00, 0);
        // Clear wins over a same-cycle mismatch.
        clr = 1'b1;
        cyc("cm_c", 8'hFF, 8'h00, 8'h00, 0, 1, 8'h04, 0);
        clr = 1'b0;
        cyc("cm_h", 8'hFF, 8'hFF, 8'hFF, 0, 0, 8'h00, 0);
        add_v[2] = 32'h1000_0040;

        // Pass-through: mode off, then a single-core group.
        mode = 1'b0;
        cyc("pt_m0", 8'hA5, 8'h00, 8'hA5, 0, 0, 8'h00, 0);
        cyc("pt_m1", 8'hFF, 8'h00, 8'hFF, 0, 0, 8'h00, 0);
        mode = 1'b1; mask = 8'h01;
        cyc("pt_g0", 8'h03, 8'h00, 8'h03, 0, 0, 8'h00, 0);
        cyc("pt_g1", 8'h5A, 8'h00, 8'h5A, 0, 0, 8'h00, 0);
        mask = 8'hFF;

        // Mode drop during HOLD returns to IDLE.
        cyc("md_c", 8'hFF, 8'h00, 8'h00, 0, 0, 8'h00, 0);
        mode = 1'b0;
        cyc("md_0", 8'hFF, 8'h00, 8'hFF, 0, 0, 8'h00, 0);
        mode = 1'b1;
        cyc("md_c2", 8'hFF, 8'h00, 8'h00, 0, 0, 8'h00, 0);
        cyc("md_h", 8'hFF, 8'hFF, 8'hFF, 1, 0, 8'h00, 0);
        cyc("md_i", 8'h00, 8'h00, 8'h00, 0, 0, 8'h00, 0);

        // Reset during HOLD clears state and counters on the next edge.
        add_v[2] = 32'h1000_0044;
        cyc("rs_c", 8'hFF, 8'h00, 8'h00, 0, 1, 8'h04, 0);
        cyc("rs_h", 8'hFF, 8'h00, 8'hFF, 0, 0, 8'h00, 0);
        rst_n = 1'b0;
        cyc("rs_a", 8'hFF, 8'h00, 8'hFF, 0, 0, 8'h00, 0);
        cyc("rs_b", 8'hFF, 8'h00, 8'h00, 0, 0, 8'h00, 0);
        rst_n = 1'b1;
        cyc("rs_i", 8'h00, 8'h00, 8'h00, 0, 0, 8'h00, 0);

        chk("sb_drain", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
